// File: rtl/dragon_stack.sv
// LIFO stack: entries 0/1 live in registers, deeper entries in a synchronous spill RAM.
// Define DRAGON_STACK_GUARD_EN to drop out-of-range ops and raise sticky Overflow/Underflow.
module dragon_stack #(
    parameter int DataWidth    = 36,
    parameter int Depth        = 512,
    parameter int AddressWidth = 9
) (
    input  logic                      Clock,
    input  logic                      ResetN,
    input  logic                      OpValid,
    input  logic [1:0]                Op,
    input  logic [DataWidth-1:0]      Data,
    output logic                      Ready,
    output logic [DataWidth-1:0]      Top,
    output logic [DataWidth-1:0]      Next,
    output logic [AddressWidth+1:0]   Count,
    output logic                      Empty,
    output logic                      Full,
    output logic                      Overflow,
    output logic                      Underflow
);
    localparam int CountWidth = AddressWidth + 2;
    localparam int RamDepth   = 1 << AddressWidth;

    typedef enum logic {READY, REFILL} state_t;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_POP2PUSH = 2'b11} op_t;

    state_t                  state;
    op_t                     op;
    logic                    accept;
    logic                    is_push;
    logic                    is_pop;
    logic                    is_p2p;
    logic                    drop_ovf;
    logic                    drop_unf;
    logic                    do_push;
    logic                    do_pop;
    logic                    do_p2p;
    logic                    count_ge2;
    logic                    count_ge3;
    logic                    ram_we;
    logic                    ram_re;
    logic [AddressWidth-1:0] ram_wa;
    logic [AddressWidth-1:0] ram_ra;
    logic [DataWidth-1:0]    ram_rd;
    logic [DataWidth-1:0]    mem [RamDepth];

    assign op        = op_t'(Op);
    assign Ready     = (state == READY);
    assign accept    = OpValid && Ready;
    assign is_push   = (op == OP_PUSH);
    assign is_pop    = (op == OP_POP);
    assign is_p2p    = (op == OP_POP2PUSH);
    assign Empty     = (Count == '0);
    assign Full      = (Count == CountWidth'(Depth));
    assign count_ge2 = (Count >= CountWidth'(2));
    assign count_ge3 = (Count >= CountWidth'(3));

    assign do_push = accept && is_push && !drop_ovf;
    assign do_pop  = accept && is_pop  && !drop_unf;
    assign do_p2p  = accept && is_p2p  && !drop_unf;

    // Entry k sits at address Count-1-k; only the low address bits matter, so subtract there.
    assign ram_we = do_push && count_ge2;
    assign ram_wa = Count[AddressWidth-1:0] - AddressWidth'(2);
    assign ram_re = (do_pop || do_p2p) && count_ge3;
    assign ram_ra = Count[AddressWidth-1:0] - AddressWidth'(3);

    always_ff @(posedge Clock) begin
        if (ram_we) begin
            mem[ram_wa] <= Next;
        end
        if (ram_re) begin
            ram_rd <= mem[ram_ra];
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= READY;
            Count <= '0;
            Top   <= '0;
            Next  <= '0;
        end else begin
            case (state)
                READY: begin
                    if (do_push) begin
                        Next  <= Top;
                        Top   <= Data;
                        Count <= Count + CountWidth'(1);
                    end else if (do_pop || do_p2p) begin
                        Top   <= do_pop ? Next : Data;
                        Count <= Count - CountWidth'(1);
                        if (count_ge3) begin
                            state <= REFILL;
                        end else begin
                            Next <= '0;
                        end
                    end
                end
                REFILL: begin
                    Next  <= ram_rd;
                    state <= READY;
                end
                default: state <= READY;
            endcase
        end
    end

`ifdef DRAGON_STACK_GUARD_EN
    assign drop_ovf = accept && is_push && Full;
    assign drop_unf = accept && ((is_pop && Empty) || (is_p2p && !count_ge2));

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (drop_ovf) begin
                Overflow <= 1'b1;
            end
            if (drop_unf) begin
                Underflow <= 1'b1;
            end
        end
    end
`else
    assign drop_ovf  = 1'b0;
    assign drop_unf  = 1'b0;
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dragon_stack.sv
// Randomized bench for dragon_stack against a queue-based stack model.
module tb_dragon_stack;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = AW + 2;
`ifdef DRAGON_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, P2P = 2'b11;

    logic          Clock;
    logic          ResetN;
    logic          OpValid;
    logic [1:0]    Op;
    logic [DW-1:0] Data;
    logic          Ready;
    logic [DW-1:0] Top;
    logic [DW-1:0] Next;
    logic [CW-1:0] Count;
    logic          Empty;
    logic          Full;
    logic          Overflow;
    logic          Underflow;

    dragon_stack #(
        .DataWidth   (DW),
        .Depth       (DEPTH),
        .AddressWidth(AW)
    ) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .OpValid  (OpValid),
        .Op       (Op),
        .Data     (Data),
        .Ready    (Ready),
        .Top      (Top),
        .Next     (Next),
        .Count    (Count),
        .Empty    (Empty),
        .Full     (Full),
        .Overflow (Overflow),
        .Underflow(Underflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    logic [DW-1:0] model_q[$];
    bit            m_ready;
    bit            m_ovf;
    bit            m_unf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        logic [DW-1:0] exp_top;
        logic [DW-1:0] exp_next;
        n        = model_q.size();
        exp_top  = (n > 0) ? model_q[0] : '0;
        exp_next = (n > 1) ? model_q[1] : '0;
        check_eq("ready", 64'(Ready), 64'(m_ready));
        check_eq("count", 64'(Count), 64'(n));
        check_eq("empty", 64'(Empty), 64'(n == 0));
        check_eq("full", 64'(Full), 64'(n == DEPTH));
        check_eq("top", 64'(Top), 64'(exp_top));
        if (m_ready) check_eq("next", 64'(Next), 64'(exp_next));
        check_eq("overflow", 64'(Overflow), 64'(m_ovf));
        check_eq("underflow", 64'(Underflow), 64'(m_unf));
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ready = 1'b1;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_apply(input logic v, input logic [1:0] o, input logic [DW-1:0] d);
        int n;
        n = model_q.size();
        if (!m_ready) begin
            m_ready = 1'b1;
        end else if (v) begin
            case (o)
                PUSH: begin
                    if (GUARD && n == DEPTH) m_ovf = 1'b1;
                    else model_q.push_front(d);
                end
                POP: begin
                    if (GUARD && n == 0) m_unf = 1'b1;
                    else begin
                        if (n > 0) void'(model_q.pop_front());
                        if (n >= 3) m_ready = 1'b0;
                    end
                end
                P2P: begin
                    if (GUARD && n < 2) m_unf = 1'b1;
                    else begin
                        if (n > 0) void'(model_q.pop_front());
                        if (n > 1) void'(model_q.pop_front());
                        model_q.push_front(d);
                        if (n >= 3) m_ready = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_op(input logic v, input logic [1:0] o, input logic [DW-1:0] d);
        @(negedge Clock);
        check_state();
        OpValid = v;
        Op      = o;
        Data    = d;
        @(posedge Clock);
        model_apply(v, o, d);
        #1;
        OpValid = 1'b0;
    endtask

    task automatic apply_reset();
        ResetN = 1'b0;
        #1;
        model_reset();
        check_state();
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          v;
        logic [1:0]    o;
        logic [DW-1:0] d;
        ResetN  = 1'b1;
        OpValid = 1'b0;
        Op      = NOP;
        Data    = '0;
        model_reset();
        #2;
        apply_reset();

        // Back-to-back pushes with no stall
        do_op(1, PUSH, 1); do_op(1, PUSH, 2); do_op(1, PUSH, 3);
        do_op(0, NOP, 0);
        // Pop into refill; the op offered during refill is ignored
        do_op(1, POP, 0); do_op(1, POP, 0); do_op(1, POP, 0);
        do_op(0, NOP, 0);

        apply_reset();
        do_op(1, PUSH, 7); do_op(1, PUSH, 4); do_op(1, PUSH, 5);
        do_op(1, P2P, 9); do_op(0, NOP, 0); do_op(1, NOP, 0);
        do_op(0, NOP, 0);

        // Reset asserted while a refill is pending
        apply_reset();
        for (int i = 0; i < 10; i++) do_op(1, PUSH, DW'(100 + i));
        do_op(1, POP, 0);
        apply_reset();

        // Fill to capacity and drain
        for (int i = 0; i < DEPTH; i++) do_op(1, PUSH, DW'(i));
        do_op(0, NOP, 0);
        for (int i = 0; i < 4 * DEPTH && model_q.size() > 0; i++) do_op(1, POP, 0);
        do_op(0, NOP, 0);
        do_op(0, NOP, 0);

        if (GUARD) begin
            apply_reset();
            for (int i = 0; i <= DEPTH; i++) do_op(1, PUSH, DW'(50 + i));
            do_op(0, NOP, 0);
            apply_reset();
            do_op(1, POP, 0);
            do_op(1, PUSH, 3);
            do_op(1, P2P, 4);
            do_op(0, NOP, 0);
        end

        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            o = 2'($urandom_range(0, 3));
            d = DW'($urandom);
            if (!GUARD) begin
                if (o == PUSH && model_q.size() >= DEPTH) o = POP;
                else if (o == POP && model_q.size() == 0) o = PUSH;
                else if (o == P2P && model_q.size() < 2) o = PUSH;
            end
            if (GUARD && $urandom_range(0, 99) == 0) apply_reset();
            do_op(v, o, d);
        end
        do_op(0, NOP, 0);
        do_op(0, NOP, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dragon_stack.md
DRAGON_STACK -- requirements
Module: DragonStack

Interface
REQ-001 SHALL have parameter DataWidth, default 36, entry width in bits.
REQ-002 SHALL have parameter Depth, default 512, total entry capacity, at least 4.
REQ-003 SHALL have parameter AddressWidth, default 9, spill-RAM address width; Depth-2 <= 2^AddressWidth.
REQ-004 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port ResetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port OpValid  input  1  operation request.
REQ-007 SHALL have port Op  input  2  00 NOP, 01 PUSH, 10 POP, 11 POP2PUSH (pop two, push one).
REQ-008 SHALL have port Data  input  DataWidth  push/result value.
REQ-009 SHALL have port Ready  output  1  operation accepted this cycle when OpValid&&Ready.
REQ-010 SHALL have port Top  output  DataWidth  entry 0, registered.
REQ-011 SHALL have port Next  output  DataWidth  entry 1, registered.
REQ-012 SHALL have port Count  output  AddressWidth+2  current occupancy, 0..Depth.
REQ-013 SHALL have ports Empty, Full  output  1 each  Count==0, Count==Depth.
REQ-014 SHALL have ports Overflow, Underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL hold entries 0 and 1 in registers Top/Next; entries 2..Count-1 in internal single-clock spill RAM with 1-cycle synchronous read, entry k at address Count-1-k.
REQ-016 SHALL implement states READY (Ready=1) and REFILL (Ready=0); no other states.
REQ-017 PUSH SHALL, in one cycle: write Next to RAM at address Count-2 when Count>=2, Next<=Top, Top<=Data, Count+1; remain READY.
REQ-018 POP SHALL: Top<=Next, Count-1; if Count>=3 before the pop, issue RAM read at address Count-3 and enter REFILL, else Next<=0 and remain READY.
REQ-019 POP2PUSH SHALL: Top<=Data, Count-1; if Count>=3, read RAM address Count-3 and enter REFILL, else Next<=0 and remain READY.
REQ-020 REFILL SHALL last exactly one cycle, load Next from RAM read data, return to READY; OpValid ignored during REFILL.
REQ-021 NOP SHALL change no state.
REQ-022 Slots at or above Count SHALL read 0 on Top/Next (Top=0 when Empty, Next=0 when Count<2).
REQ-023 Count arithmetic SHALL be unsigned, width AddressWidth+2, never wrapping when DRAGON_STACK_GUARD_EN is defined.
REQ-024 Ready SHALL be combinational from state only, never from OpValid.

Reset
REQ-025 ResetN low SHALL asynchronously force: state READY, Count=0, Top=0, Next=0, Overflow=0, Underflow=0; Empty=1, Full=0, Ready=1 follow.
REQ-026 Reset during REFILL SHALL abandon the refill; spill RAM contents need not be cleared.
REQ-027 First operation SHALL be accepted on the first rising edge after ResetN deasserts.

Configuration
REQ-028 Macro DRAGON_STACK_GUARD_EN defined: PUSH at Full SHALL be dropped and set Overflow; POP at Count==0 or POP2PUSH at Count<2 SHALL be dropped and set Underflow; dropped ops change no other state; flags clear only by reset.
REQ-029 Macro DRAGON_STACK_GUARD_EN undefined: Overflow and Underflow SHALL be constant 0; out-of-range ops execute unchecked with Count wrapping modulo 2^(AddressWidth+2); stack contents thereafter undefined.

Verification
REQ-030 Reset, PUSH 1,2,3 back-to-back -> Top=3, Next=2, Count=3, Ready=1 every cycle.
REQ-031 From [3,2,1], POP -> Top=2, Ready=0 one cycle, then Next=1, Count=2; second POP next READY cycle -> Top=1, Next=0, no stall.
REQ-032 From [5,4,7], POP2PUSH Data=9 -> Top=9, REFILL one cycle, Next=7, Count=2.
REQ-033 Depth=4, guard on: push 4 values, fifth PUSH -> Overflow=1, Count=4, Top unchanged; POP from empty after reset -> Underflow=1, Count=0.
REQ-034 Push 10 values, assert ResetN low mid-REFILL -> immediately Count=0, Top=0, Ready=1, Empty=1.
REQ-035 Push Depth values 0..Depth-1, pop all -> Top sequence Depth-1 down to 0, Empty=1 at end, flags 0.
